// File: rtl/rgmii_tx_arbiter_if.sv
// rgmii_tx_arbiter_if: requester-side and MAC-side AXI-Stream bundle for the tx arbiter.
interface rgmii_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata_i;
   logic [NUM_REQ-1:0]            s_tvalid_i;
   logic [NUM_REQ-1:0]            s_tlast_i;
   logic [NUM_REQ-1:0]            s_tready_o;
   logic [DATA_WIDTH-1:0]         m_tdata_o;
   logic                          m_tvalid_o;
   logic                          m_tlast_o;
   logic                          m_tuser_o;
   logic                          m_tready_i;
   modport master (
      input  s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
      output s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o
   );
   modport slave (
      output s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
      input  s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o
   );
endinterface

// File: rtl/rgmii_tx_arbiter.sv
// rgmii_tx_arbiter: frame-level round-robin arbiter in front of the RGMII MAC tx stream.
// Optional per-requester frame/truncation counters under RGMII_TX_ARB_STATS_EN.
module rgmii_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 2048,
   parameter int IFG_CYCLES = 12
) (
   input  logic                 clk_i,
   input  logic                 arstn_i,
   input  logic                 enable_i,
   rgmii_tx_arbiter_if.master   bus,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o
`ifdef RGMII_TX_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] frame_cnt_o,
   output logic [15:0]           trunc_cnt_o
`endif
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BEATS);
   localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PASS, DROP, GAP} state_t;

   state_t         state_q, state_d, end_st;
   logic [IW-1:0]  last_q, last_d, pick_idx, cand;
   logic [BW-1:0]  beat_q, beat_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           pick_ok, own_valid, own_last, full, hs;

   assign own_valid = bus.s_tvalid_i[last_q];
   assign own_last  = bus.s_tlast_i[last_q];
   assign full      = &beat_q;
   assign hs        = state_q == PASS && own_valid && bus.m_tready_i;
   assign end_st    = IFG_CYCLES == 0 ? IDLE : GAP;

   // Scan from the far end so the nearest requester after last_q wins.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = last_q;
      cand     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IW'((int'(last_q) + i) % NUM_REQ);
         if (bus.s_tvalid_i[cand]) begin
            pick_ok  = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i)
      if (!arstn_i) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         beat_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
      end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: if (enable_i && pick_ok) begin
            state_d = PASS;
            last_d  = pick_idx;
            beat_d  = '0;
         end
         PASS: if (hs) begin
            beat_d  = beat_q + 1'b1;
            state_d = own_last ? end_st : full ? DROP : PASS;
         end
         DROP: if (own_valid && own_last) state_d = end_st;
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (int'(gap_q) == IFG_CYCLES - 1) begin
               state_d = IDLE;
               gap_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.m_tdata_o = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (state_q == PASS && last_q == IW'(k)) bus.m_tdata_o = bus.s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      bus.m_tvalid_o = state_q == PASS && own_valid;
      bus.m_tlast_o  = state_q == PASS && (own_last || full);
      bus.m_tuser_o  = state_q == PASS && full && !own_last;
      bus.s_tready_o = state_q == PASS ? NUM_REQ'(bus.m_tready_i) << last_q :
                       state_q == DROP ? NUM_REQ'(1) << last_q : '0;
      grant_o        = state_q == PASS || state_q == DROP ? NUM_REQ'(1) << last_q : '0;
      busy_o         = state_q != IDLE;
   end

`ifdef RGMII_TX_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] frame_q, frame_d;
   logic [15:0]           trunc_q, trunc_d;

   always_ff @(posedge clk_i or negedge arstn_i)
      if (!arstn_i) begin
         frame_q <= '0;
         trunc_q <= '0;
      end else begin
         frame_q <= frame_d;
         trunc_q <= trunc_d;
      end

   // A truncated frame still ends with a forwarded tlast, so it counts as a frame too.
   always_comb begin
      frame_d = frame_q;
      trunc_d = trunc_q + 16'(hs && full && !own_last);
      for (int k = 0; k < NUM_REQ; k++)
         if (hs && (own_last || full) && last_q == IW'(k)) frame_d[k*16 +: 16] = frame_q[k*16 +: 16] + 16'd1;
   end

   assign frame_cnt_o = frame_q;
   assign trunc_cnt_o = trunc_q;
`endif
endmodule

// File: doc/rgmii_tx_arbiter.md
Name: rgmii_tx_arbiter

Overview:
Frame-level round-robin arbiter that shares the RGMII MAC transmit AXI-Stream input between NUM_REQ requesters, such as a CPU packet path, hardware UDP generators and a loopback path.
- Once granted, a requester owns the output until its tlast beat.
- Enforces a programmable inter-frame idle gap.
- Truncates runaway frames longer than MAX_BEATS.
- Sits directly in front of the MAC s_axis port, in the tx clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, tdata width per requester
MAX_BEATS, 2048, maximum beats per frame before forced truncation (power of 2)
IFG_CYCLES, 12, idle cycles inserted after every frame end (0 allowed)

Ports:
clk_i  in  1  tx clock
arstn_i  in  1  asynchronous active-low reset
enable_i  in  1  1 = new grants allowed; 0 = finish current frame, then hold idle
s_tdata_i  in  NUM_REQ*DATA_WIDTH  requester data, requester k at slice k
s_tvalid_i  in  NUM_REQ  per-requester valid
s_tlast_i  in  NUM_REQ  per-requester last
s_tready_o  out  NUM_REQ  per-requester ready
m_tdata_o  out  DATA_WIDTH  to MAC
m_tvalid_o  out  1  to MAC
m_tlast_o  out  1  to MAC
m_tuser_o  out  1  1 on the last beat of a truncated frame
m_tready_i  in  1  from MAC
grant_o  out  NUM_REQ  one-hot current owner, 0 when none
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE; all outputs 0.
  - Round-robin pointer last_q = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If enable_i=1 and any s_tvalid_i bit is set, pick the first valid index scanning last_q+1, last_q+2, ... modulo NUM_REQ.
  - Register it into grant/last_q; next state = PASS.
  - Arbitration latency is one cycle; no data passes in IDLE, and all s_tready_o are 0.
- PASS:
  - Combinational mux for the owner g:
    - m_tdata_o = s_tdata_i[g]
    - m_tvalid_o = s_tvalid_i[g]
    - m_tlast_o = s_tlast_i[g]
    - s_tready_o[g] = m_tready_i
  - Other s_tready_o bits are 0. Zero added latency.
  - beat_q counts handshakes (log2(MAX_BEATS) bits) and clears on grant.
  - Handshake with s_tlast_i[g]=1 → GAP, or IDLE if IFG_CYCLES=0.
  - Handshake with beat_q = MAX_BEATS-1 and tlast=0: the beat goes out with m_tlast_o=1 and m_tuser_o=1 → DROP.
  - m_tuser_o is 0 otherwise.
- DROP:
  - s_tready_o[g]=1; m_tvalid_o=0.
  - Discard owner beats until the owner's tlast handshake → GAP (or IDLE).
- GAP:
  - All outputs idle; count IFG_CYCLES cycles → IDLE.
  - Owner to next owner's first beat is ≥ IFG_CYCLES+1 cycles.
- grant_o holds the owner one-hot through PASS/DROP and is 0 in GAP/IDLE.
- enable_i is sampled only in IDLE; deasserting it mid-frame never cuts a frame.
- Requester dropping tvalid mid-frame: the grant is held, with no timeout.
- MAC stalls (m_tready_i=0): m_tvalid_o/m_tdata_o mirror the owner, and the beat counter does not advance.
- Simultaneous requests: strict rotation; no requester wins twice while another is waiting.

Optional Feature:
Macro RGMII_TX_ARB_STATS_EN.
- Defined, it adds:
  - Output frame_cnt_o [NUM_REQ*16]: per-requester count of frames forwarded, incremented on the output tlast handshake, wrapping at 16'hFFFF→0.
  - Output trunc_cnt_o [16]: count of truncated frames.
  - All counters reset to 0.
- Undefined: these ports and their logic are absent.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then req0 alone sends 5 beats with m_tready_i=1 → grant_o=0001 one cycle after valid; 5 beats out; tlast on beat 5; 12 idle cycles, then busy_o=0.
- Reqs 0,1,2 all valid with 3-beat frames continuously → output order 0,1,2,0,1,2, each separated by ≥13 cycles.
- Req1 frame of MAX_BEATS+10 beats → output beat 2048 has m_tlast_o=1, m_tuser_o=1; remaining 10 beats consumed with m_tvalid_o=0; next grant proceeds normally.
- m_tready_i toggling 1/0 every cycle during an 8-beat frame → exactly 8 handshakes, data order preserved, no duplicated or lost beats.
- enable_i dropped on beat 2 of a 6-beat frame while req3 waits → frame completes; no new grant while enable_i=0; req3 granted one cycle after re-enable (post-gap).
- With RGMII_TX_ARB_STATS_EN: 3 frames from req2 plus 1 truncated frame from req0 → frame_cnt_o[2]=3, frame_cnt_o[0]=1, trunc_cnt_o=1.
